// File: rtl/token_engine_pkg.sv
// Shared types and defaults for the token-engine pop executor.
package token_engine_pkg;

  localparam int NUM_FIFO_DEF = 32;
  localparam int CNT_W_DEF    = 32;

  // Per-lane life cycle: idle after reset/clear, popping, or finished (sticky).
  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_POP  = 2'd1,
    L_DONE = 2'd2
  } lane_state_e;

endpackage

// File: rtl/fifo_pop_executor_if.sv
// Pop-request bus between the controllers, the FIFO bank and the pop executor.
interface fifo_pop_executor_if #(
  parameter int NUM_FIFO = 32,
  parameter int CNT_W    = 32
);

  logic                               clear;
  logic [NUM_FIFO-1:0]                need_pop;
  logic [NUM_FIFO-1:0][CNT_W-1:0]     pop_num;
  logic [NUM_FIFO-1:0]                fifo_empty;
  logic [NUM_FIFO-1:0]                pe_ready;
  logic [NUM_FIFO-1:0]                fifo_pop;
  logic [NUM_FIFO-1:0]                done_matrix;
  logic                               all_done;
  logic                               busy;
  logic                               overrun;

  // Requester / environment side.
  modport master (
    output clear, need_pop, pop_num, fifo_empty, pe_ready,
    input  fifo_pop, done_matrix, all_done, busy, overrun
  );

  // Executor side.
  modport slave (
    input  clear, need_pop, pop_num, fifo_empty, pe_ready,
    output fifo_pop, done_matrix, all_done, busy, overrun
  );

endinterface

// File: rtl/fifo_pop_lane.sv
// One FIFO lane: request FSM, remaining-pop counter and pop strobe.
module fifo_pop_lane
  import token_engine_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             need_pop_i,
  input  logic [CNT_W-1:0] pop_num_i,
  input  logic             fifo_empty_i,
  input  logic             pe_ready_i,
  output logic             fifo_pop_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             overrun_o
);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             overrun_q, overrun_d;
  logic             pop;

  // Pop only when popping with data and a willing PE; a new request or a clear
  // in the same cycle suppresses the pop so the old count is never consumed.
  assign pop = (state_q == L_POP) && !fifo_empty_i && pe_ready_i &&
               !need_pop_i && !clear_i && (rem_q != '0);

  // Next state: clear beats a request, a request beats an ongoing pop.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    overrun_d = 1'b0;
    if (clear_i) begin
      state_d = L_IDLE;
      rem_d   = '0;
    end else if (need_pop_i) begin
      rem_d     = pop_num_i;
      state_d   = (pop_num_i != '0) ? L_POP : L_DONE;
      overrun_d = (state_q == L_POP);
    end else begin
      case (state_q)
        L_IDLE: state_d = L_IDLE;
        L_POP: begin
          if (pop) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = L_DONE;
            end
          end
        end
        L_DONE: state_d = L_DONE;
        default: state_d = L_IDLE;
      endcase
    end
  end

  // Lane registers, asynchronously returned to idle by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= L_IDLE;
      rem_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      overrun_q <= overrun_d;
    end
  end

  assign fifo_pop_o = pop;
  assign done_o     = (state_q == L_DONE);
  assign busy_o     = (state_q == L_POP);
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/fifo_pop_executor.sv
// Pop executor: NUM_FIFO independent lanes plus the cross-lane status reductions.
module fifo_pop_executor
  import token_engine_pkg::*;
#(
  parameter int NUM_FIFO = NUM_FIFO_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_pop_executor_if.slave  bus
);

  logic [NUM_FIFO-1:0] done_vec;
  logic [NUM_FIFO-1:0] busy_vec;
  logic [NUM_FIFO-1:0] overrun_vec;

  generate
    for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_lane
      fifo_pop_lane #(.CNT_W(CNT_W)) u_lane (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (bus.clear),
        .need_pop_i   (bus.need_pop[gi]),
        .pop_num_i    (bus.pop_num[gi]),
        .fifo_empty_i (bus.fifo_empty[gi]),
        .pe_ready_i   (bus.pe_ready[gi]),
        .fifo_pop_o   (bus.fifo_pop[gi]),
        .done_o       (done_vec[gi]),
        .busy_o       (busy_vec[gi]),
        .overrun_o    (overrun_vec[gi])
      );
    end
  endgenerate

  // Overrun flags are already registered per lane, so the OR stays glitch-free.
  assign bus.done_matrix = done_vec;
  assign bus.all_done    = &done_vec;
  assign bus.busy        = |busy_vec;
  assign bus.overrun     = |overrun_vec;

endmodule

// File: tb/tb_fifo_pop_executor.sv
// Self-checking bench for fifo_pop_executor against a cycle-level reference model.
module tb_fifo_pop_executor;

  localparam int NF = 32;
  localparam int CW = 32;

  logic clk;
  logic rst_n;

  fifo_pop_executor_if #(.NUM_FIFO(NF), .CNT_W(CW)) bus ();

  fifo_pop_executor #(.NUM_FIFO(NF), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per lane, whether a request is still being served, whether
  // it has completed, and how many pops are still owed.
  bit [NF-1:0]    m_active;
  bit [NF-1:0]    m_done;
  longint         m_rem [NF];
  bit             m_ovr;
  logic [NF-1:0]  exp_pop;

  // Observation helpers for directed latency checks.
  int rel;
  int popcnt [NF];
  int first_done [NF];
  int first_all;
  int ovr_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = '0;
    m_done   = '0;
    m_ovr    = 1'b0;
    for (int k = 0; k < NF; k++) m_rem[k] = 0;
  endtask

  // Apply one clock worth of the request rules to the model.
  task automatic model_step();
    bit ovr_n;
    if (!rst_n || bus.clear) begin
      model_reset();
      return;
    end
    ovr_n = 1'b0;
    for (int k = 0; k < NF; k++) begin
      if (bus.need_pop[k]) begin
        if (m_active[k]) ovr_n = 1'b1;
        m_rem[k]    = longint'(bus.pop_num[k]);
        m_active[k] = (m_rem[k] != 0);
        m_done[k]   = (m_rem[k] == 0);
      end else if (exp_pop[k]) begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_active[k] = 1'b0;
          m_done[k]   = 1'b1;
        end
      end
    end
    m_ovr = ovr_n;
  endtask

  task automatic arm();
    rel = 0;
    first_all = -1;
    ovr_seen = 0;
    for (int k = 0; k < NF; k++) begin
      popcnt[k] = 0;
      first_done[k] = -1;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then drop pulses.
  task automatic cycle();
    @(negedge clk);
    exp_pop = m_active & ~bus.fifo_empty & bus.pe_ready & ~bus.need_pop & {NF{~bus.clear}};
    if (!rst_n) exp_pop = '0;
    check("fifo_pop",    64'(bus.fifo_pop),    64'(exp_pop));
    check("done_matrix", 64'(bus.done_matrix), 64'(m_done));
    check("all_done",    64'(bus.all_done),    64'(&m_done));
    check("busy",        64'(bus.busy),        64'(|m_active));
    check("overrun",     64'(bus.overrun),     64'(m_ovr));
    for (int k = 0; k < NF; k++) begin
      if (bus.fifo_pop[k]) popcnt[k]++;
      if (rel >= 1 && bus.done_matrix[k] && first_done[k] < 0) first_done[k] = rel;
    end
    if (rel >= 1 && bus.all_done && first_all < 0) first_all = rel;
    if (bus.overrun) ovr_seen++;
    model_step();
    @(posedge clk);
    #1;
    bus.need_pop = '0;
    bus.clear    = 1'b0;
    rel++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int lane;
    rst_n          = 1'b0;
    bus.clear      = 1'b0;
    bus.need_pop   = '0;
    bus.pop_num    = '0;
    bus.fifo_empty = '0;
    bus.pe_ready   = '1;
    model_reset();
    arm();

    // Reset state.
    run(3);
    rst_n = 1'b1;
    run(2);

    // 1: every lane pops once.
    arm();
    bus.need_pop = '1;
    for (int k = 0; k < NF; k++) bus.pop_num[k] = 32'd1;
    run(5);
    check("t1_all_done_at", 64'(first_all), 64'd2);
    check("t1_pops_lane0", 64'(popcnt[0]), 64'd1);
    check("t1_pops_lane31", 64'(popcnt[31]), 64'd1);
    $display("txn t1 single-pop wave: all_done at +%0d", first_all);

    // 2: different counts per lane, two zero-count lanes.
    arm();
    bus.need_pop = '1;
    for (int k = 0; k < NF; k++) bus.pop_num[k] = (k < 3) ? 32'd3 : (k < 30) ? 32'(k + 1) : 32'd0;
    run(40);
    check("t2_lane30_done_at", 64'(first_done[30]), 64'd1);
    check("t2_lane0_done_at", 64'(first_done[0]), 64'd4);
    check("t2_lane29_done_at", 64'(first_done[29]), 64'd31);
    check("t2_lane29_pops", 64'(popcnt[29]), 64'd30);
    check("t2_all_done_at", 64'(first_all), 64'd31);
    $display("txn t2 mixed-count wave: all_done at +%0d", first_all);

    // 3: stall on lane 5.
    arm();
    bus.need_pop[5] = 1'b1;
    bus.pop_num[5]  = 32'd4;
    cycle();
    for (int t = 1; t <= 12; t++) begin
      bus.fifo_empty[5] = (t == 2 || t == 3);
      cycle();
    end
    bus.fifo_empty = '0;
    check("t3_lane5_pops", 64'(popcnt[5]), 64'd4);
    check("t3_lane5_done_at", 64'(first_done[5]), 64'd7);
    $display("txn t3 stall lane 5: pops %0d done at +%0d", popcnt[5], first_done[5]);

    // 4: reload while popping.
    arm();
    bus.need_pop[2] = 1'b1;
    bus.pop_num[2]  = 32'd10;
    run(4);
    bus.need_pop[2] = 1'b1;
    bus.pop_num[2]  = 32'd2;
    run(8);
    check("t4_lane2_pops", 64'(popcnt[2]), 64'd5);
    check("t4_overrun_pulses", 64'(ovr_seen), 64'd1);
    $display("txn t4 overrun lane 2: pops %0d overrun pulses %0d", popcnt[2], ovr_seen);

    // 5: clear collides with a new request.
    arm();
    bus.need_pop = '1;
    for (int k = 0; k < NF; k++) bus.pop_num[k] = 32'd8;
    run(3);
    bus.clear    = 1'b1;
    bus.need_pop = '1;
    cycle();
    check("t5_done_after_clear", 64'(bus.done_matrix), 64'd0);
    check("t5_busy_after_clear", 64'(bus.busy), 64'd0);
    check("t5_overrun_after_clear", 64'(bus.overrun), 64'd0);
    check("t5_lane0_pops", 64'(popcnt[0]), 64'd2);
    run(3);
    $display("txn t5 clear+request: lane0 pops %0d", popcnt[0]);

    // 6: reset in the middle of a run.
    arm();
    bus.need_pop = '1;
    for (int k = 0; k < NF; k++) bus.pop_num[k] = 32'd5;
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pop_in_reset", 64'(bus.fifo_pop), 64'd0);
    check("t6_done_in_reset", 64'(bus.done_matrix), 64'd0);
    check("t6_busy_in_reset", 64'(bus.busy), 64'd0);
    check("t6_overrun_in_reset", 64'(bus.overrun), 64'd0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    arm();
    lane = int'($urandom_range(NF - 1, 0));
    bus.need_pop[lane] = 1'b1;
    bus.pop_num[lane]  = 32'd3;
    run(8);
    check("t6_pops_after_reset", 64'(popcnt[lane]), 64'd3);
    check("t6_done_after_reset", 64'(first_done[lane]), 64'd4);
    $display("txn t6 reset mid-run, lane %0d rerun pops %0d", lane, popcnt[lane]);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NF; k++) begin
        bus.need_pop[k]   = ($urandom_range(15, 0) == 0);
        bus.pop_num[k]    = 32'($urandom_range(6, 0));
        bus.fifo_empty[k] = ($urandom_range(3, 0) == 0);
        bus.pe_ready[k]   = ($urandom_range(3, 0) != 0);
      end
      bus.clear = ($urandom_range(99, 0) == 0);
      cycle();
    end
    $display("txn random: 400 cycles of mixed traffic");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
